// File: rtl/gradient_calc.sv
// Streaming spatio-temporal gradient stage: central-difference Ix/Iy on the current frame
// plus temporal difference It, emitted for every interior pixel with its coordinates.
module gradient_calc #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    localparam int XW = $clog2(IMAGE_WIDTH),
    localparam int YW = $clog2(IMAGE_HEIGHT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PIXEL_WIDTH-1:0]        pixel_curr,
    input  logic [PIXEL_WIDTH-1:0]        pixel_prev,
    input  logic                          pixel_valid,
    input  logic                          frame_done,
    output logic signed [PIXEL_WIDTH:0]   grad_ix,
    output logic signed [PIXEL_WIDTH:0]   grad_iy,
    output logic signed [PIXEL_WIDTH:0]   grad_it,
    output logic [XW-1:0]                 grad_x,
    output logic [YW-1:0]                 grad_y,
    output logic                          grad_valid,
    output logic                          grad_done,
    output logic                          frame_err
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t          state, state_next;
    logic [XW-1:0]   in_x, next_x;
    logic [YW-1:0]   in_y, next_y;
    logic            last_col, last_row, interior, truncate;

    logic [PIXEL_WIDTH-1:0] line1 [IMAGE_WIDTH];
    logic [PIXEL_WIDTH-1:0] line2 [IMAGE_WIDTH];
    logic [PIXEL_WIDTH-1:0] line_prev [IMAGE_WIDTH];
    logic [PIXEL_WIDTH-1:0] rd1, rd2, rd_prev;
    logic [PIXEL_WIDTH-1:0] c1_d1, c1_d2, c2_d1, c0_d1, p1_d1;
    logic signed [PIXEL_WIDTH:0] ix, iy, it;

    assign last_col = (in_x == XW'(IMAGE_WIDTH - 1));
    assign last_row = (in_y == YW'(IMAGE_HEIGHT - 1));
    assign interior = (in_x >= XW'(2)) && (in_y >= YW'(2));

    // Pixel is advanced first; frame_done is then judged against the advanced counters.
    always_comb begin
        state_next = state;
        next_x     = in_x;
        next_y     = in_y;
        truncate   = 1'b0;
        if (pixel_valid) begin
            if (last_col) begin
                next_x = '0;
                next_y = last_row ? '0 : in_y + YW'(1);
            end else begin
                next_x = in_x + XW'(1);
            end
        end
        case (state)
            IDLE:    if (pixel_valid) state_next = STREAM;
            STREAM:  if (pixel_valid && last_col && last_row) state_next = DONE;
            DONE:    state_next = pixel_valid ? STREAM : IDLE;
            default: state_next = IDLE;
        endcase
        if (frame_done && (next_x != '0 || next_y != '0)) begin
            truncate   = 1'b1;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_x      <= '0;
            in_y      <= '0;
            frame_err <= 1'b0;
        end else begin
            state <= state_next;
            in_x  <= truncate ? '0 : next_x;
            in_y  <= truncate ? '0 : next_y;
            if (truncate) frame_err <= 1'b1;
        end
    end

    assign grad_done = (state == DONE);

    assign rd1     = line1[in_x];
    assign rd2     = line2[in_x];
    assign rd_prev = line_prev[in_x];

    // Line buffers and column windows carry no reset; interior gating hides stale contents.
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            line1[in_x]     <= pixel_curr;
            line2[in_x]     <= rd1;
            line_prev[in_x] <= pixel_prev;
            c1_d1           <= rd1;
            c1_d2           <= c1_d1;
            c2_d1           <= rd2;
            c0_d1           <= pixel_curr;
            p1_d1           <= rd_prev;
        end
    end

    assign ix = $signed({1'b0, rd1})   - $signed({1'b0, c1_d2});
    assign iy = $signed({1'b0, c0_d1}) - $signed({1'b0, c2_d1});
    assign it = $signed({1'b0, c1_d1}) - $signed({1'b0, p1_d1});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grad_ix    <= '0;
            grad_iy    <= '0;
            grad_it    <= '0;
            grad_x     <= '0;
            grad_y     <= '0;
            grad_valid <= 1'b0;
        end else begin
            grad_valid <= pixel_valid && interior;
            if (pixel_valid && interior) begin
                grad_ix <= ix;
                grad_iy <= iy;
                grad_it <= it;
                grad_x  <= in_x - XW'(1);
                grad_y  <= in_y - YW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gradient_calc.sv
// Self-checking bench for gradient_calc: table of frame patterns, reference model feeding a
// scoreboard queue, plus hand-written truncation and mid-frame reset sequences.
module tb_gradient_calc;

    localparam int PW = 8;
    localparam int W  = 260;
    localparam int H  = 5;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int OUTS_PER_FRAME = (W - 2) * (H - 2);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [PW-1:0]        pixel_curr, pixel_prev;
    logic                 pixel_valid, frame_done;
    logic signed [PW:0]   grad_ix, grad_iy, grad_it;
    logic [XW-1:0]        grad_x;
    logic [YW-1:0]        grad_y;
    logic                 grad_valid, grad_done, frame_err;

    gradient_calc #(.PIXEL_WIDTH(PW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .pixel_curr(pixel_curr), .pixel_prev(pixel_prev),
        .pixel_valid(pixel_valid), .frame_done(frame_done),
        .grad_ix(grad_ix), .grad_iy(grad_iy), .grad_it(grad_it),
        .grad_x(grad_x), .grad_y(grad_y),
        .grad_valid(grad_valid), .grad_done(grad_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ix, iy, it, gx, gy, done, cyc;
    } exp_t;

    typedef struct {
        string name;
        int    kind;
        int    gap;
        bit    fixed;
        int    eix, eiy, eit;
    } case_t;

    exp_t       sbq[$];
    logic [7:0] cimg [H][W];
    logic [7:0] pimg [H][W];
    int checks = 0, failures = 0;
    int cyc = 0, out_count = 0, done_count = 0;
    bit fixed_mode;
    int fix_ix, fix_iy, fix_it;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (grad_valid) begin
            out_count++;
            if (grad_done) done_count++;
            if (sbq.size() == 0) begin
                checkOutput("unexpected_output_x", int'(grad_x), -1);
            end else begin
                e = sbq.pop_front();
                checkOutput("ix", int'(grad_ix), e.ix);
                checkOutput("iy", int'(grad_iy), e.iy);
                checkOutput("it", int'(grad_it), e.it);
                checkOutput("grad_x", int'(grad_x), e.gx);
                checkOutput("grad_y", int'(grad_y), e.gy);
                checkOutput("grad_done", int'(grad_done), e.done);
                checkOutput("latency_cycle", cyc, e.cyc);
            end
        end else if (grad_done) begin
            checkOutput("done_without_valid", 1, 0);
        end
    end

    task automatic fillFrame(input int kind);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (kind)
                    0: begin cimg[y][x] = 8'h80; pimg[y][x] = 8'h80; end
                    1: begin cimg[y][x] = 8'(x % 256); pimg[y][x] = cimg[y][x]; end
                    2: begin cimg[y][x] = 8'(y); pimg[y][x] = cimg[y][x]; end
                    3: begin cimg[y][x] = 8'h00; pimg[y][x] = 8'hFF; end
                    4: begin cimg[y][x] = 8'hFF; pimg[y][x] = 8'h00; end
                    5: begin
                        pimg[y][x] = (x >= 100 && x < 140 && y >= 1 && y <= 3) ? 8'hFF : 8'h00;
                        cimg[y][x] = (x >= 101 && x < 141 && y >= 1 && y <= 3) ? 8'hFF : 8'h00;
                    end
                    default: begin cimg[y][x] = 8'($urandom); pimg[y][x] = 8'($urandom); end
                endcase
            end
        end
    endtask

    // Drives one pixel (after optional random idle cycles) and queues its expected result.
    task automatic applyStimulus(input int x, input int y, input int gap, input bit fd);
        exp_t e;
        while (gap > 0 && $urandom_range(99) < gap) begin
            pixel_valid = 1'b0;
            frame_done  = 1'b0;
            @(posedge clk); #1;
        end
        pixel_valid = 1'b1;
        pixel_curr  = cimg[y][x];
        pixel_prev  = pimg[y][x];
        frame_done  = fd;
        if (x >= 2 && y >= 2) begin
            e.ix   = int'(cimg[y-1][x]) - int'(cimg[y-1][x-2]);
            e.iy   = int'(cimg[y][x-1]) - int'(cimg[y-2][x-1]);
            e.it   = int'(cimg[y-1][x-1]) - int'(pimg[y-1][x-1]);
            if (fixed_mode) begin
                e.ix = fix_ix; e.iy = fix_iy; e.it = fix_it;
            end
            e.gx   = x - 1;
            e.gy   = y - 1;
            e.done = (x == W - 1 && y == H - 1) ? 1 : 0;
            e.cyc  = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        frame_done  = 1'b0;
    endtask

    task automatic sendFrame(input int gap, input bit fd_last);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                applyStimulus(x, y, gap, fd_last && x == W - 1 && y == H - 1);
    endtask

    task automatic endFrame(input string nm);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({nm, "_drained"}, sbq.size(), 0);
        checkOutput({nm, "_count"}, out_count, OUTS_PER_FRAME);
        checkOutput({nm, "_done_pulses"}, done_count, 1);
        out_count  = 0;
        done_count = 0;
    endtask

    case_t cases[9];

    initial begin
        cases[0] = '{"uniform",        0, 0,  1, 0, 0, 0};
        cases[1] = '{"uniform_gaps",   0, 50, 1, 0, 0, 0};
        cases[2] = '{"ramp_x",         1, 0,  0, 0, 0, 0};
        cases[3] = '{"ramp_x_gaps",    1, 50, 0, 0, 0, 0};
        cases[4] = '{"ramp_y",         2, 0,  1, 0, 2, 0};
        cases[5] = '{"temporal_neg",   3, 0,  1, 0, 0, -255};
        cases[6] = '{"temporal_pos",   4, 0,  1, 0, 0, 255};
        cases[7] = '{"shifted_square", 5, 0,  0, 0, 0, 0};
        cases[8] = '{"random_gaps",    6, 30, 0, 0, 0, 0};

        rst_n = 1'b0; pixel_valid = 1'b0; frame_done = 1'b0;
        pixel_curr = '0; pixel_prev = '0; fixed_mode = 1'b0;
        fix_ix = 0; fix_iy = 0; fix_it = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", int'(grad_valid), 0);
        checkOutput("rst_done", int'(grad_done), 0);
        checkOutput("rst_err", int'(frame_err), 0);
        checkOutput("rst_ix", int'(grad_ix), 0);
        checkOutput("rst_x", int'(grad_x), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (cases[i]) begin
            fillFrame(cases[i].kind);
            fixed_mode = cases[i].fixed;
            fix_ix = cases[i].eix; fix_iy = cases[i].eiy; fix_it = cases[i].eit;
            sendFrame(cases[i].gap, 1'b0);
            endFrame(cases[i].name);
        end
        fixed_mode = 1'b0;
        checkOutput("err_after_clean_frames", int'(frame_err), 0);

        // frame_done while idle is ignored
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_frame_done_err", int'(frame_err), 0);

        // frame_done together with the final pixel completes normally
        fillFrame(6);
        sendFrame(0, 1'b1);
        endFrame("fd_with_last");
        checkOutput("fd_with_last_err", int'(frame_err), 0);

        // truncated frame: 600 pixels reach row 2 up to x=79
        fillFrame(6);
        for (int n = 0; n < 600; n++) applyStimulus(n % W, n / W, 0, 1'b0);
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("trunc_err", int'(frame_err), 1);
        checkOutput("trunc_count", out_count, 78);
        checkOutput("trunc_done_pulses", done_count, 0);
        checkOutput("trunc_drained", sbq.size(), 0);
        out_count = 0; done_count = 0;
        fillFrame(6);
        sendFrame(20, 1'b0);
        endFrame("after_trunc");
        checkOutput("err_sticky", int'(frame_err), 1);

        // reset mid-frame
        fillFrame(1);
        for (int n = 0; n < 700; n++) applyStimulus(n % W, n / W, 0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midrst_valid", int'(grad_valid), 0);
        checkOutput("midrst_err", int'(frame_err), 0);
        checkOutput("midrst_ix", int'(grad_ix), 0);
        checkOutput("midrst_y", int'(grad_y), 0);
        checkOutput("midrst_drained", sbq.size(), 0);
        rst_n = 1'b1;
        out_count = 0; done_count = 0;
        @(posedge clk); #1;
        fillFrame(5);
        sendFrame(0, 1'b0);
        endFrame("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
